// File: rtl/dest_hazard_pipe_pkg.sv
// Shared types and constants for the destination/hazard pipeline.
// Holds the stage-entry layout and the operand-forward select encodings.
package dest_hazard_pipe_pkg;

  localparam int ADDR_W = 6;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // wen is stored already qualified: valid, requested, and dest != r0.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              wen;
    logic              is_load;
  } stage_t;

  // The youngest producer wins, so an EX hit shadows a MEM hit.
  function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_hit)       sel = FWD_MEM;
    else if (mem_hit) sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/dest_hazard_pipe_stage_reg.sv
// One pipeline entry register with bubble insertion.
// Used for the EX, MEM and WB entries of dest_hazard_pipe.
module dest_stage_reg
  import dest_hazard_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (bubble) q <= '0;
    else             q <= d;
  end

endmodule

// File: rtl/dest_hazard_pipe.sv
// Carries decode destinations through EX/MEM/WB and derives forwarding
// selects, the load-use stall, the register-file write port and a stall counter.
module dest_hazard_pipe #(
  parameter int ADDR_W = dest_hazard_pipe_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic [ADDR_W-1:0] id_src_a,
  input  logic [ADDR_W-1:0] id_src_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_dest,
  output logic              ex_wen,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_dest,
  output logic              mem_wen,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_dest,
  output logic              wb_wen,
  output logic [CNT_W-1:0]  stall_count
);
  import dest_hazard_pipe_pkg::*;

  stage_t           ex_d, ex_p0, mem_p1, wb_p2;
  logic             id_ewen;
  logic             ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic             ex_bubble;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] cnt;

  function automatic logic src_hit(input stage_t s, input logic used,
                                   input logic [ADDR_W-1:0] src);
    return s.valid & s.wen & used & (s.dest == src);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Decode: hazard detection against the EX and MEM entries
  assign id_ewen   = id_valid & id_wen & (id_dest != '0);
  assign ex_hit_a  = src_hit(ex_p0,  id_use_a, id_src_a);
  assign ex_hit_b  = src_hit(ex_p0,  id_use_b, id_src_b);
  assign mem_hit_a = src_hit(mem_p1, id_use_a, id_src_a);
  assign mem_hit_b = src_hit(mem_p1, id_use_b, id_src_b);
  assign fwd_a     = fwd_pick(ex_hit_a, mem_hit_a);
  assign fwd_b     = fwd_pick(ex_hit_b, mem_hit_b);

  assign stall = rst_n & id_valid & ~flush & ex_p0.is_load & (ex_hit_a | ex_hit_b);

  assign ex_bubble = stall | flush | ~id_valid;

  always_comb begin
    ex_d         = '0;
    ex_d.valid   = id_valid;
    ex_d.dest    = id_dest;
    ex_d.wen     = id_ewen;
    ex_d.is_load = id_valid & id_is_load;
  end

  // EX entry and its registered forward selects
  dest_stage_reg u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (ex_bubble),
    .d      (ex_d),
    .q      (ex_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_fwd_a <= FWD_RF;
      ex_fwd_b <= FWD_RF;
    end else if (ex_bubble) begin
      ex_fwd_a <= FWD_RF;
      ex_fwd_b <= FWD_RF;
    end else begin
      ex_fwd_a <= fwd_a;
      ex_fwd_b <= fwd_b;
    end
  end

  // MEM and WB entries always advance
  dest_stage_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (ex_p0),
    .q      (mem_p1)
  );

  dest_stage_reg u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (mem_p1),
    .q      (wb_p2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (stall) cnt <= sat_inc(cnt);
  end

  assign ex_valid    = ex_p0.valid;
  assign ex_dest     = ex_p0.dest;
  assign ex_wen      = ex_p0.wen;
  assign mem_valid   = mem_p1.valid;
  assign mem_dest    = mem_p1.dest;
  assign mem_wen     = mem_p1.wen;
  assign wb_valid    = wb_p2.valid;
  assign wb_dest     = wb_p2.dest;
  assign wb_wen      = wb_p2.wen;
  assign stall_count = cnt;

endmodule

// File: tb/tb_dest_hazard_pipe.sv
// Scoreboard bench for dest_hazard_pipe: a history-based reference model
// predicts stalls and per-stage outputs; a monitor checks what the DUT presents.
module tb_dest_hazard_pipe;
  localparam int AW = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 0, id_wen = 0, id_is_load = 0, id_use_a = 0, id_use_b = 0, flush = 0;
  logic [AW-1:0] id_dest = '0, id_src_a = '0, id_src_b = '0;
  logic          stall, ex_valid, ex_wen, mem_valid, mem_wen, wb_valid, wb_wen;
  logic [AW-1:0] ex_dest, mem_dest, wb_dest;
  logic [1:0]    ex_fwd_a, ex_fwd_b;
  logic [CW-1:0] stall_count;

  dest_hazard_pipe #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_dest(id_dest), .id_wen(id_wen),
    .id_is_load(id_is_load), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_wen(ex_wen),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_wen(mem_wen),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_wen(wb_wen),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit [AW-1:0] dest; bit wen; bit ld;
    bit [AW-1:0] sa; bit ua; bit [AW-1:0] sb; bit ub; bit fl;
  } ins_t;
  typedef struct { bit v; bit [AW-1:0] dest; bit ewen; bit ld; } ent_t;
  typedef struct { int cyc; bit [AW-1:0] dest; bit ewen; bit [1:0] fa; bit [1:0] fb; } exp_t;

  exp_t exq[$], memq[$], wbq[$];
  ent_t hist[$];   // what entered EX at the last edges, youngest first
  int   mcount, cyc, ntests, nfail;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic ins_t mk(bit v, int dest, bit wen, bit ld, int sa, bit ua, int sb, bit ub, bit fl);
    ins_t i;
    i.v = v; i.dest = AW'(dest); i.wen = wen; i.ld = ld;
    i.sa = AW'(sa); i.ua = ua; i.sb = AW'(sb); i.ub = ub; i.fl = fl;
    return i;
  endfunction

  function automatic bit produces(int age, bit [AW-1:0] src, bit rd);
    if (!rd || hist.size() <= age) return 1'b0;
    return hist[age].v && hist[age].ewen && hist[age].dest == src;
  endfunction

  function automatic bit [1:0] model_fwd(bit [AW-1:0] src, bit rd);
    if (produces(0, src, rd)) return 2'b01;
    if (produces(1, src, rd)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input ins_t i, output bit stalled);
    ent_t e;
    exp_t x;
    bit   exp_stall, acc;
    @(negedge clk);
    id_valid = i.v; id_dest = i.dest; id_wen = i.wen; id_is_load = i.ld;
    id_src_a = i.sa; id_use_a = i.ua; id_src_b = i.sb; id_use_b = i.ub; flush = i.fl;
    #1;
    exp_stall = i.v && !i.fl && hist.size() > 0 && hist[0].ld &&
                (produces(0, i.sa, i.ua) || produces(0, i.sb, i.ub));
    chk("stall", stall, exp_stall);
    chk("stall_count", stall_count, mcount);
    acc = i.v && !i.fl && !exp_stall;
    e = '{v: acc, dest: acc ? i.dest : '0, ewen: acc && i.wen && i.dest != 0, ld: acc && i.ld};
    if (acc) begin
      x = '{cyc: cyc + 1, dest: i.dest, ewen: e.ewen, fa: model_fwd(i.sa, i.ua), fb: model_fwd(i.sb, i.ub)};
      exq.push_back(x);
      x.cyc = cyc + 2; memq.push_back(x);
      x.cyc = cyc + 3; wbq.push_back(x);
    end
    hist.push_front(e);
    if (hist.size() > 2) void'(hist.pop_back());
    if (exp_stall && mcount != (1 << CW) - 1) mcount++;
    stalled = exp_stall;
  endtask

  task automatic clear_model();
    exq.delete(); memq.delete(); wbq.delete(); hist.delete(); mcount = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valids"}, {ex_valid, mem_valid, wb_valid}, 0);
    chk({tag, "_wens"}, {ex_wen, mem_wen, wb_wen}, 0);
    chk({tag, "_dests"}, {ex_dest, mem_dest, wb_dest}, 0);
    chk({tag, "_fwd"}, {ex_fwd_a, ex_fwd_b}, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_count"}, stall_count, 0);
  endtask

  // Monitor: pops expectations whenever a stage presents a valid entry
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        while (exq.size() && exq[0].cyc < cyc) begin chk("ex_missing", 0, 1); void'(exq.pop_front()); end
        while (memq.size() && memq[0].cyc < cyc) begin chk("mem_missing", 0, 1); void'(memq.pop_front()); end
        while (wbq.size() && wbq[0].cyc < cyc) begin chk("wb_missing", 0, 1); void'(wbq.pop_front()); end
        if (ex_valid) begin
          if (exq.size() == 0 || exq[0].cyc != cyc) chk("ex_unexpected", 1, 0);
          else begin
            chk("ex_entry", {ex_dest, ex_wen, ex_fwd_a, ex_fwd_b},
                {exq[0].dest, exq[0].ewen, exq[0].fa, exq[0].fb});
            void'(exq.pop_front());
          end
        end else chk("ex_bubble", {ex_wen, ex_fwd_a, ex_fwd_b}, 0);
        if (mem_valid) begin
          if (memq.size() == 0 || memq[0].cyc != cyc) chk("mem_unexpected", 1, 0);
          else begin
            chk("mem_entry", {mem_dest, mem_wen}, {memq[0].dest, memq[0].ewen});
            void'(memq.pop_front());
          end
        end else chk("mem_idle_wen", mem_wen, 0);
        if (wb_valid) begin
          if (wbq.size() == 0 || wbq[0].cyc != cyc) chk("wb_unexpected", 1, 0);
          else begin
            chk("wb_write", {wb_dest, wb_wen}, {wbq[0].dest, wbq[0].ewen});
            void'(wbq.pop_front());
          end
        end else chk("wb_idle_wen", wb_wen, 0);
      end
    end
  end

  initial begin
    ins_t idle, cur;
    bit   st;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single write walks to WB
    step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0), st);
    repeat (4) step(idle, st);

    // ALU forwarding chain on r3
    step(mk(1, 3, 1, 0, 0, 0, 0, 0, 0), st);
    step(mk(1, 4, 1, 0, 3, 1, 0, 0, 0), st);
    @(posedge clk); #1; chk("plan_fwd_mem", ex_fwd_a, 2'b01);
    step(mk(1, 6, 1, 0, 0, 0, 3, 1, 0), st);
    @(posedge clk); #1; chk("plan_fwd_wb", ex_fwd_b, 2'b10);
    step(mk(1, 8, 1, 0, 3, 1, 3, 1, 0), st);
    @(posedge clk); #1; chk("plan_fwd_rf", {ex_fwd_a, ex_fwd_b}, 0);
    repeat (3) step(idle, st);

    // load-use stall, then the held consumer takes the WB forward
    step(mk(1, 7, 1, 1, 0, 0, 0, 0, 0), st);
    cur = mk(1, 9, 1, 0, 0, 0, 7, 1, 0);
    step(cur, st);
    chk("plan_ld_stall", st, 1);
    @(posedge clk); #1; chk("plan_ld_bubble", ex_valid, 0); chk("plan_ld_cnt", stall_count, 1);
    step(cur, st);
    chk("plan_ld_nostall", st, 0);
    @(posedge clk); #1; chk("plan_ld_fwd", {ex_valid, ex_fwd_b}, 3'b110);
    repeat (3) step(idle, st);

    // flush overrides the load-use stall
    step(mk(1, 7, 1, 1, 0, 0, 0, 0, 0), st);
    step(mk(1, 9, 1, 0, 0, 0, 7, 1, 1), st);
    chk("plan_flush_stall", st, 0);
    @(posedge clk); #1; chk("plan_flush_ex", ex_valid, 0); chk("plan_flush_cnt", stall_count, 1);
    repeat (3) step(idle, st);

    // r0 is never a producer
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), st);
    step(mk(1, 2, 1, 0, 0, 1, 0, 0, 0), st);
    @(posedge clk); #1; chk("plan_r0_fwd", ex_fwd_a, 0);
    repeat (4) step(idle, st);

    // counter saturation
    repeat (20) begin
      step(mk(1, 1, 1, 1, 0, 0, 0, 0, 0), st);
      cur = mk(1, 2, 1, 0, 1, 1, 0, 0, 0);
      step(cur, st);
      if (st) step(cur, st);
    end
    step(idle, st);
    chk("sat_count", stall_count, (1 << CW) - 1);

    // asynchronous reset with three instructions in flight
    step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), st);
    step(mk(1, 2, 1, 0, 0, 0, 0, 0, 0), st);
    step(mk(1, 3, 1, 0, 1, 1, 2, 1, 0), st);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    clear_model();
    id_valid = 0; id_wen = 0; id_is_load = 0; id_use_a = 0; id_use_b = 0; flush = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(idle, st);

    // randomized traffic on a small register set; stalled instructions are held
    st = 0;
    cur = idle;
    repeat (600) begin
      if (!st) begin
        cur.v = $urandom_range(0, 99) < 85;
        cur.dest = AW'($urandom_range(0, 3));
        cur.wen = $urandom_range(0, 99) < 80;
        cur.ld = $urandom_range(0, 99) < 40;
        cur.sa = AW'($urandom_range(0, 3));
        cur.ua = $urandom_range(0, 1);
        cur.sb = AW'($urandom_range(0, 3));
        cur.ub = $urandom_range(0, 1);
      end
      cur.fl = $urandom_range(0, 99) < 10;
      step(cur, st);
    end

    repeat (5) step(idle, st);
    chk("drain_queues", exq.size() + memq.size() + wbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dest_hazard_pipe.md
# dest_hazard_pipe

Carries the destination-register field chosen at decode through the EX, MEM and WB pipeline stages. It compares each decoding instruction's source registers against the in-flight destinations. From that comparison it produces the operand-forwarding selects, the load-use stall, and the register-file write address and enable. It sits directly downstream of the decode-stage destination selector and upstream of the register-file write port and the EX operand muxes.

## Interface
Parameters:
- `ADDR_W`, default 6: register-address width.
- `CNT_W`, default 16: stall-counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `id_valid`, in, 1: decode slot holds a real instruction.
- `id_dest`, in, ADDR_W: destination from the destination selector.
- `id_wen`, in, 1: instruction writes a register.
- `id_is_load`, in, 1: instruction is a load (result available after MEM).
- `id_src_a` / `id_src_b`, in, ADDR_W: source register addresses.
- `id_use_a` / `id_use_b`, in, 1: source is actually read.
- `flush`, in, 1: squash the decode instruction (branch taken in EX).
- `stall`, out, 1: hold fetch/decode this cycle; combinational.
- `ex_valid`, `ex_dest`, `ex_wen`, out, 1/ADDR_W/1: EX-stage entry.
- `ex_fwd_a` / `ex_fwd_b`, out, 2: operand select for the EX instruction.
- `mem_valid`, `mem_dest`, `mem_wen`, out, 1/ADDR_W/1: MEM-stage entry.
- `wb_valid`, `wb_dest`, `wb_wen`, out, 1/ADDR_W/1: register-file write port.
- `stall_count`, out, CNT_W: saturating count of stall cycles.

## Operation
- Three stage registers (EX, MEM, WB). Each holds valid, dest, wen and is_load. All advance every cycle; there is no back-pressure beyond `stall`.
- Effective write enable at entry is `id_valid & id_wen & (id_dest != 0)`. Register 0 is never a producer.
- Source match for a stage: the stage is valid with effective wen, the source is used, and the source equals the stage's dest.
- Forward encodings are computed at decode and registered into `ex_fwd_*` at the edge:
  - `00`: register file.
  - `01`: MEM result. The producer is currently in EX.
  - `10`: WB result. The producer is currently in MEM.
- The youngest producer wins: an EX match beats a MEM match.
- A WB-stage match yields `00`. The register file is write-before-read within a cycle.
- Load-use hazard: `stall = id_valid & ~flush & EX.valid & EX.wen & EX.is_load & (match_a | match_b)`.
- On a stall:
  - A bubble (valid=0, wen=0, fwd=00) enters EX.
  - MEM and WB advance normally.
  - The decode inputs are held by upstream, and the hazard is re-evaluated next cycle.
- On `flush`:
  - A bubble enters EX.
  - `stall` is forced to 0.
  - Flush overrides stall.
- Otherwise the decode instruction is loaded into EX with its computed forward selects.
- `stall_count` increments on every cycle in which `stall` is 1 and saturates at all-ones.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream) forces:
  - all valid and wen outputs to 0;
  - all dest outputs to 0;
  - `ex_fwd_a`/`ex_fwd_b` to `00`;
  - `stall_count` to 0.
- `stall` evaluates to 0 while reset is asserted.
- Latency: a decode instruction accepted at edge N appears in EX after edge N, in MEM after N+1, and on `wb_*` after N+2. That is 3 edges from decode to register-file write.
- `stall` is combinational from the registered EX state and the `id_*` inputs. It is valid in the same cycle.
- A load-use stall lasts exactly 1 cycle. After the bubble, the load sits in MEM and the consumer receives `10`.
- Reset asserted mid-stream discards all in-flight entries. No write is issued while `rst_n` is 0.
- A simultaneous match on both sources to different stages gives independent selects per operand.

## Structure
- Shared package holds:
  - `ADDR_W`;
  - the forward constants `FWD_RF=2'b00`, `FWD_MEM=2'b01`, `FWD_WB=2'b10`;
  - a packed stage-entry struct (valid, dest, wen, is_load).
- One sub-module, `dest_stage_reg`: a resettable entry register with a bubble-insert control. It is instantiated for EX, MEM and WB.
- Match logic, forward priority, stall logic and the counter live in the top level.

## Test plan
- Reset, then `id_dest=5`, `id_wen=1`, `id_valid=1` for one cycle, then idle. Expect `ex_dest=5` after edge 1, `mem_dest=5` after edge 2, and `wb_dest=5` with `wb_wen=1` after edge 3. `stall` stays 0 throughout.
- `add r3` followed by `sub` with `src_a=3`, `use_a=1`. Expect `ex_fwd_a=01`. A third instruction reading r3 gets `ex_fwd_b=10` if it reads r3 through `src_b`. A fourth instruction gets `00`.
- Load to r7, then a consumer with `src_b=7`. Expect `stall=1` for exactly one cycle, `stall_count` 0→1, and a bubble in EX. The consumer then enters EX with `ex_fwd_b=10`.
- Load to r7 with a consumer presented alongside `flush=1`. Expect `stall=0`, `ex_valid=0` after the edge, and `stall_count` unchanged.
- An instruction writing r0 followed by one reading r0. Expect `ex_fwd_a=00` and `wb_wen=0` for the r0 writer.
- Assert `rst_n=0` while three instructions are in flight. Expect all valid, wen and fwd outputs to go to 0 immediately, without waiting for a clock edge, and no `wb_wen` pulse after release.
